// File: rtl/alu_pkg.sv
// Shared encodings for the ID->EX ALU control stage.
// Build option: ALU_FPU_EN enables FADD/FMUL decode and latency countdown.
package alu_pkg;

  localparam logic [1:0] OP_MEM = 2'b00;
  localparam logic [1:0] OP_BR  = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_FPU = 2'b11;

  localparam logic [3:0] CTRL_ADD  = 4'b0000;
  localparam logic [3:0] CTRL_SUB  = 4'b0001;
  localparam logic [3:0] CTRL_AND  = 4'b0010;
  localparam logic [3:0] CTRL_OR   = 4'b0011;
  localparam logic [3:0] CTRL_XOR  = 4'b0100;
  localparam logic [3:0] CTRL_SLT  = 4'b0101;
  localparam logic [3:0] CTRL_SLTU = 4'b0110;
  localparam logic [3:0] CTRL_SLL  = 4'b0111;
  localparam logic [3:0] CTRL_SRL  = 4'b1000;
  localparam logic [3:0] CTRL_SRA  = 4'b1001;
  localparam logic [3:0] CTRL_FADD = 4'b1110;
  localparam logic [3:0] CTRL_FMUL = 4'b1111;

  localparam logic [1:0] BE_BYTE = 2'b00;
  localparam logic [1:0] BE_HALF = 2'b01;
  localparam logic [1:0] BE_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [1:0] be;
    logic       is_fpu;
    logic [3:0] lat;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// Handshake and decode bus between ID, the ALU control stage and EX.
// Build option: ALU_FPU_EN (affects only the stage behaviour).
interface alu_ctrl_stage_if #(
  parameter int CTRL_W = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        ALUOp;
  logic [2:0]        funct3;
  logic              funct7_5;
  logic              rtype;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] ALUCtrl;
  logic [1:0]        be;
  logic              fpu_busy;

  modport master (
    output flush, in_valid, ALUOp, funct3,
    output funct7_5, rtype, out_ready,
    input  in_ready, out_valid, ALUCtrl,
    input  be, fpu_busy
  );

  modport slave (
    input  flush, in_valid, ALUOp, funct3,
    input  funct7_5, rtype, out_ready,
    output in_ready, out_valid, ALUCtrl,
    output be, fpu_busy
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct3/funct7_5 decode to ALU control code and byte enable.
// Build option: ALU_FPU_EN enables FADD/FMUL decode.
import alu_pkg::*;

module alu_ctrl_decode #(
  parameter int FADD_LAT = 3,
  parameter int FMUL_LAT = 4
) (
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       rtype_i,
  output dec_t       dec_o
);

  logic [3:0] fpu_lat;

  always_comb begin
    fpu_lat = 4'd0;
    if (funct3_i == 3'b000) fpu_lat = 4'(FADD_LAT);
    if (funct3_i == 3'b001) fpu_lat = 4'(FMUL_LAT);
  end

  always_comb begin
    dec_o.ctrl   = CTRL_ADD;
    dec_o.be     = BE_BYTE;
    dec_o.is_fpu = 1'b0;
    dec_o.lat    = fpu_lat;
    unique case (alu_op_i)
      OP_MEM: begin
        unique case (funct3_i)
          3'b001:  dec_o.be = BE_HALF;
          3'b010:  dec_o.be = BE_WORD;
          default: dec_o.be = BE_BYTE;
        endcase
      end
      OP_BR: begin
        unique case (funct3_i)
          3'b110, 3'b111: dec_o.ctrl = CTRL_SLTU;
          3'b010, 3'b011: dec_o.ctrl = CTRL_ADD;
          default:        dec_o.ctrl = CTRL_SUB;
        endcase
      end
      OP_ALU: begin
        unique case (funct3_i)
          3'b000: dec_o.ctrl = (rtype_i & funct7_5_i)
                             ? CTRL_SUB : CTRL_ADD;
          3'b001: dec_o.ctrl = CTRL_SLL;
          3'b010: dec_o.ctrl = CTRL_SLT;
          3'b011: dec_o.ctrl = CTRL_SLTU;
          3'b100: dec_o.ctrl = CTRL_XOR;
          3'b101: dec_o.ctrl = funct7_5_i
                             ? CTRL_SRA : CTRL_SRL;
          3'b110: dec_o.ctrl = CTRL_OR;
          default: dec_o.ctrl = CTRL_AND;
        endcase
      end
      default: begin
`ifdef ALU_FPU_EN
        unique case (funct3_i)
          3'b000: begin
            dec_o.ctrl   = CTRL_FADD;
            dec_o.is_fpu = 1'b1;
          end
          3'b001: begin
            dec_o.ctrl   = CTRL_FMUL;
            dec_o.is_fpu = 1'b1;
          end
          default: dec_o.ctrl = CTRL_ADD;
        endcase
`else
        dec_o.ctrl = CTRL_ADD;
`endif
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU control stage with valid/ready handshake and FPU latency stall.
// Build option: ALU_FPU_EN enables the BUSY countdown for FADD/FMUL.
import alu_pkg::*;

module alu_ctrl_stage #(
  parameter int FADD_LAT = 3,
  parameter int FMUL_LAT = 4,
  parameter int CTRL_W   = 4
) (
  input logic             clk,
  input logic             rst,
  alu_ctrl_stage_if.slave bus
);

  state_e     state_q, state_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic [1:0] be_q, be_d;
  logic       in_ready;
  logic       accept;
  dec_t       dec;

  alu_ctrl_decode #(
    .FADD_LAT(FADD_LAT),
    .FMUL_LAT(FMUL_LAT)
  ) u_dec (
    .alu_op_i  (bus.ALUOp),
    .funct3_i  (bus.funct3),
    .funct7_5_i(bus.funct7_5),
    .rtype_i   (bus.rtype),
    .dec_o     (dec)
  );

  assign in_ready = (state_q == ST_EMPTY) |
                    ((state_q == ST_FULL) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready & ~bus.flush;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.ALUCtrl   = CTRL_W'(ctrl_q);
  assign bus.be        = be_q;

`ifdef ALU_FPU_EN
  logic [3:0] cnt_q, cnt_d;

  assign bus.fpu_busy = (state_q == ST_BUSY);

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
      cnt_d   = 4'd0;
    end else if (accept) begin
      ctrl_d = dec.ctrl;
      be_d   = dec.be;
      if (dec.is_fpu && dec.lat != 4'd0) begin
        state_d = ST_BUSY;
        cnt_d   = dec.lat;
      end else begin
        state_d = ST_FULL;
      end
    end else begin
      case (state_q)
        ST_BUSY: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_FULL;
        end
        ST_FULL: if (bus.out_ready) state_d = ST_EMPTY;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_fpu;

  // Without the FPU every op, including ALUOp 11, completes in one cycle.
  assign unused_fpu   = ^{dec.is_fpu, dec.lat};
  assign bus.fpu_busy = 1'b0;

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    be_d    = be_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      ctrl_d  = dec.ctrl;
      be_d    = dec.be;
      state_d = ST_FULL;
    end else if (state_q == ST_FULL && bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ctrl_q  <= CTRL_ADD;
      be_q    <= BE_BYTE;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      be_q    <= be_d;
    end
  end

endmodule
